// File: rtl/lc3_pipe_ctrl.sv
// LC3 pipeline controller: registered stage enables, memory access state and
// branch-taken flag, plus combinational operand bypass selects.
`timescale 1ns/1ps
module lc3_pipe_ctrl (
  input  logic        clock,
  input  logic        reset,
  input  logic        complete_instr,
  input  logic        complete_data,
  input  logic [15:0] IR,
  input  logic [15:0] IR_Exec,
  input  logic [15:0] IMem_dout,
  input  logic [2:0]  NZP,
  output logic        enable_updatePC,
  output logic        enable_fetch,
  output logic        enable_decode,
  output logic        enable_execute,
  output logic        enable_writeback,
  output logic        bypass_alu_1,
  output logic        bypass_alu_2,
  output logic        bypass_mem_1,
  output logic        bypass_mem_2,
  output logic [1:0]  mem_state,
  output logic        br_taken,
  output logic [2:0]  fsm_state
);

  typedef enum logic [2:0] {
    S_FILL       = 3'd0,
    S_RUN        = 3'd1,
    S_MEM_IND    = 3'd2,
    S_MEM_RD     = 3'd3,
    S_MEM_WR     = 3'd4,
    S_CTRL_STALL = 3'd5
  } state_t;

  localparam logic [3:0] OP_BR  = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_LD  = 4'b0010;
  localparam logic [3:0] OP_ST  = 4'b0011;
  localparam logic [3:0] OP_AND = 4'b0101;
  localparam logic [3:0] OP_LDR = 4'b0110;
  localparam logic [3:0] OP_STR = 4'b0111;
  localparam logic [3:0] OP_NOT = 4'b1001;
  localparam logic [3:0] OP_LDI = 4'b1010;
  localparam logic [3:0] OP_STI = 4'b1011;
  localparam logic [3:0] OP_JMP = 4'b1100;
  localparam logic [3:0] OP_LEA = 4'b1110;

  localparam logic [1:0] MS_READ  = 2'b00;
  localparam logic [1:0] MS_IND   = 2'b01;
  localparam logic [1:0] MS_WRITE = 2'b10;
  localparam logic [1:0] MS_IDLE  = 2'b11;

  // Enable vector order: {updatePC, fetch, decode, execute, writeback}.
  localparam logic [4:0] EN_ALL   = 5'b11111;
  localparam logic [4:0] EN_NONE  = 5'b00000;
  localparam logic [4:0] EN_STALL = 5'b00111;
  localparam logic [4:0] EN_NOPC  = 5'b01111;

  state_t     state, state_n;
  logic [1:0] fill_cnt, fill_n;
  logic [1:0] stall_cnt, stall_n;
  logic       stall_pend, pend_n;
  logic       ind_store, ind_st_n;
  logic [4:0] en_q, en_n;
  logic [1:0] ms_q, ms_n;
  logic       br_q, br_n;

  logic [3:0] exec_op, ir_op, fetch_op;
  logic [2:0] dr;
  logic       exec_ld, exec_ind, exec_st, exec_mem;
  logic       ctrl_fetch, br_cond;
  state_t     mem_entry;
  logic [1:0] mem_entry_ms;
  logic       run, prod_alu, prod_mem, src1_hit, src2_hit;
  logic       unused_bits;

  assign exec_op  = IR_Exec[15:12];
  assign ir_op    = IR[15:12];
  assign fetch_op = IMem_dout[15:12];
  assign dr       = IR_Exec[11:9];

  assign exec_ld  = (exec_op == OP_LD)  || (exec_op == OP_LDR);
  assign exec_ind = (exec_op == OP_LDI) || (exec_op == OP_STI);
  assign exec_st  = (exec_op == OP_ST)  || (exec_op == OP_STR);
  assign exec_mem = exec_ld || exec_ind || exec_st;

  assign ctrl_fetch = complete_instr && ((fetch_op == OP_BR) || (fetch_op == OP_JMP));
  assign br_cond    = (exec_op == OP_JMP) || ((exec_op == OP_BR) && (|(IR_Exec[11:9] & NZP)));

  assign unused_bits = ^{IR[11:9], IR[4:3], IR_Exec[8:0], IMem_dout[11:0]};

  always_comb begin
    mem_entry    = S_MEM_RD;
    mem_entry_ms = MS_READ;
    if (exec_ind) begin
      mem_entry    = S_MEM_IND;
      mem_entry_ms = MS_IND;
    end else if (exec_st) begin
      mem_entry    = S_MEM_WR;
      mem_entry_ms = MS_WRITE;
    end
  end

  // Memory handshake: a MEM_* state is entered on one edge and holds until an
  // edge where complete_data=1; the strobe is ignored in every other state.
  always_comb begin
    state_n  = state;
    fill_n   = fill_cnt;
    stall_n  = stall_cnt;
    pend_n   = stall_pend;
    ind_st_n = ind_store;
    en_n     = EN_ALL;
    ms_n     = MS_IDLE;
    br_n     = 1'b0;
    case (state)
      S_FILL: begin
        en_n   = {1'b1, 1'b1, fill_cnt != 2'd0, fill_cnt >= 2'd2, fill_cnt == 2'd3};
        fill_n = fill_cnt + 2'd1;
        if (fill_cnt == 2'd3) state_n = S_RUN;
      end
      S_RUN: begin
        if (exec_mem) begin
          state_n  = mem_entry;
          ms_n     = mem_entry_ms;
          en_n     = EN_NONE;
          ind_st_n = (exec_op == OP_STI);
        end else if (ctrl_fetch) begin
          state_n = S_CTRL_STALL;
          stall_n = 2'd0;
          en_n    = EN_STALL;
        end else if (!complete_instr) begin
          en_n = EN_NOPC;
        end
      end
      S_MEM_IND: begin
        en_n = EN_NONE;
        ms_n = MS_IND;
        if (complete_data) begin
          state_n = ind_store ? S_MEM_WR : S_MEM_RD;
          ms_n    = ind_store ? MS_WRITE : MS_READ;
        end
      end
      S_MEM_RD, S_MEM_WR: begin
        en_n = EN_NONE;
        ms_n = (state == S_MEM_RD) ? MS_READ : MS_WRITE;
        if (complete_data) begin
          ms_n = MS_IDLE;
          // A control stall interrupted by this access picks up where it froze.
          if (stall_pend) begin
            state_n = S_CTRL_STALL;
            pend_n  = 1'b0;
            en_n    = EN_STALL;
          end else begin
            state_n = S_RUN;
            en_n    = EN_ALL;
          end
        end
      end
      S_CTRL_STALL: begin
        if (exec_mem) begin
          state_n  = mem_entry;
          ms_n     = mem_entry_ms;
          en_n     = EN_NONE;
          ind_st_n = (exec_op == OP_STI);
          pend_n   = 1'b1;
        end else if (stall_cnt == 2'd2) begin
          state_n = S_RUN;
          br_n    = br_cond;
        end else begin
          stall_n = stall_cnt + 2'd1;
          en_n    = EN_STALL;
        end
      end
      default: begin
        state_n = S_FILL;
        en_n    = EN_NONE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state      <= S_FILL;
      fill_cnt   <= 2'd0;
      stall_cnt  <= 2'd0;
      stall_pend <= 1'b0;
      ind_store  <= 1'b0;
      en_q       <= EN_NONE;
      ms_q       <= MS_IDLE;
      br_q       <= 1'b0;
    end else begin
      state      <= state_n;
      fill_cnt   <= fill_n;
      stall_cnt  <= stall_n;
      stall_pend <= pend_n;
      ind_store  <= ind_st_n;
      en_q       <= en_n;
      ms_q       <= ms_n;
      br_q       <= br_n;
    end
  end

  assign enable_updatePC  = en_q[4];
  assign enable_fetch     = en_q[3];
  assign enable_decode    = en_q[2];
  assign enable_execute   = en_q[1];
  assign enable_writeback = en_q[0];
  assign mem_state        = ms_q;
  assign br_taken         = br_q;
  assign fsm_state        = state;

  assign run      = (state == S_RUN);
  assign prod_alu = (exec_op == OP_ADD) || (exec_op == OP_AND) ||
                    (exec_op == OP_NOT) || (exec_op == OP_LEA);
  assign prod_mem = (exec_op == OP_LD) || (exec_op == OP_LDR) || (exec_op == OP_LDI);
  assign src1_hit = ((ir_op == OP_ADD) || (ir_op == OP_AND) || (ir_op == OP_NOT) ||
                     (ir_op == OP_LDR) || (ir_op == OP_STR) || (ir_op == OP_JMP)) &&
                    (IR[8:6] == dr);
  assign src2_hit = ((ir_op == OP_ADD) || (ir_op == OP_AND)) && !IR[5] && (IR[2:0] == dr);

  assign bypass_alu_1 = run && prod_alu && src1_hit;
  assign bypass_alu_2 = run && prod_alu && src2_hit;
  assign bypass_mem_1 = run && prod_mem && src1_hit;
  assign bypass_mem_2 = run && prod_mem && src2_hit;

endmodule
